// File: rtl/mux_pkg.sv
// Shared definitions for the mux family: mode encodings and a width helper
// that never returns zero, so single-entry ranges still get a 1-bit field.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned bits;
    bits = $clog2(value);
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Channel/dwell sweep counter for scan mode: holds each channel for DWELL
// enabled cycles and wraps explicitly at N_CH-1.
module scan_counter
  import mux_pkg::*;
#(
  parameter int unsigned N_CH  = 16,
  parameter int unsigned DWELL = 1,
  localparam int unsigned SEL_W = clog2_min1(N_CH),
  localparam int unsigned DW_W  = clog2_min1(DWELL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [SEL_W-1:0] ch_q,
  output logic [DW_W-1:0]  dwell_q,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] LastCh = SEL_W'(N_CH - 1);
  localparam logic [DW_W-1:0]  LastDw = DW_W'(DWELL - 1);

  logic [SEL_W-1:0] ch_d;
  logic [DW_W-1:0]  dwell_d;
  logic             dwell_done;
  logic             last_ch;

  assign dwell_done = (dwell_q == LastDw);
  assign last_ch    = (ch_q == LastCh);
  assign wrap       = !clr && en && dwell_done && last_ch;

  always_comb begin
    ch_d    = ch_q;
    dwell_d = dwell_q;
    if (clr) begin
      ch_d    = '0;
      dwell_d = '0;
    end else if (en) begin
      if (dwell_done) begin
        dwell_d = '0;
        // Explicit wrap keeps non-power-of-2 channel counts in range.
        ch_d    = last_ch ? '0 : ch_q + 1'b1;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q    <= '0;
      dwell_q <= '0;
    end else begin
      ch_q    <= ch_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered N-to-1 mux with manual select or a time-division scan that tags
// each sample with its channel index and marks the start of every frame.
module mux_scan_nx1
  import mux_pkg::*;
#(
  parameter int unsigned N_CH  = 16,
  parameter int unsigned W     = 1,
  parameter int unsigned DWELL = 1,
  localparam int unsigned SEL_W = clog2_min1(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] data,
  input  logic              mode,
  input  logic [SEL_W-1:0]  select,
  input  logic              en,
  output logic [W-1:0]      y,
  output logic [SEL_W-1:0]  ch,
  output logic              valid,
  output logic              frame_start
);

  localparam int unsigned   DW_W   = clog2_min1(DWELL);
  localparam logic [SEL_W:0] NChExt = (SEL_W + 1)'(N_CH);

  if (N_CH < 2) begin : g_bad_n_ch
    $fatal(1, "mux_scan_nx1: N_CH must be at least 2");
  end
  if (W < 1) begin : g_bad_w
    $fatal(1, "mux_scan_nx1: W must be at least 1");
  end
  if (DWELL < 1) begin : g_bad_dwell
    $fatal(1, "mux_scan_nx1: DWELL must be at least 1");
  end

  logic [SEL_W-1:0] scan_ch;
  logic [DW_W-1:0]  scan_dw;
  logic             unused_wrap;
  logic             scan_mode;

  assign scan_mode = (mode == MODE_SCAN);

  scan_counter #(
    .N_CH  (N_CH),
    .DWELL (DWELL)
  ) u_scan_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!scan_mode),
    .en      (en),
    .ch_q    (scan_ch),
    .dwell_q (scan_dw),
    .wrap    (unused_wrap)
  );

  logic [SEL_W-1:0] sel_eff;
  logic             in_range;
  logic [W-1:0]     y_sel;

  assign sel_eff  = scan_mode ? scan_ch : select;
  assign in_range = ({1'b0, sel_eff} < NChExt);

  always_comb begin
    y_sel = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (sel_eff == SEL_W'(k)) y_sel = data[k*W +: W];
    end
  end

  logic [W-1:0]     y_q, y_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             valid_q, valid_d;
  logic             frame_start_q, frame_start_d;

  always_comb begin
    y_d           = in_range ? y_sel : '0;
    // Out-of-range manual selects still report the raw index.
    ch_d          = sel_eff;
    valid_d       = (scan_mode ? en : 1'b1) && in_range;
    frame_start_d = scan_mode && en && (scan_ch == '0) && (scan_dw == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q           <= '0;
      ch_q          <= '0;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      y_q           <= y_d;
      ch_q          <= ch_d;
      valid_q       <= valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign y           = y_q;
  assign ch          = ch_q;
  assign valid       = valid_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/mux_scan_nx1.md
# mux_scan_nx1

Parametrised, registered N-to-1 multiplexer with W-bit channels and two modes: manual (channel chosen by `select`) and scan (an internal counter sweeps all channels, holding each for DWELL cycles). It generalises the 16x1 single-bit combinational mux into a time-division sampler. It sits between a bank of parallel sources and a single serial consumer that needs per-sample channel tags and a frame marker.

## Interface
Parameters:
- `N_CH`, 16, number of input channels (≥2, need not be a power of 2)
- `W`, 1, bits per channel (≥1)
- `DWELL`, 1, cycles each channel is held in scan mode (≥1)
- Derived localparams: `SEL_W = max(1, clog2(N_CH))`; `DW_W = max(1, clog2(DWELL))`

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `data` in N_CH*W: channel k occupies `data[k*W +: W]`
- `mode` in 1: 0 = manual, 1 = scan
- `select` in SEL_W: channel index, used in manual mode only
- `en` in 1: scan advance enable; ignored in manual mode
- `y` out W: registered selected channel
- `ch` out SEL_W: index of the channel currently on `y`
- `valid` out 1: `y` carries a qualified sample
- `frame_start` out 1: `y` carries channel 0, first dwell cycle of a scan frame

## Operation
- Scan state: `ch_q` (SEL_W bits) and `dwell_q` (DW_W bits).
- Effective select: `sel_eff = mode ? ch_q : select`.
- Every rising edge:
  - `y <= (sel_eff < N_CH) ? data[sel_eff*W +: W] : 0`
  - `ch <= sel_eff`
  - `valid <= (mode ? en : 1) && (sel_eff < N_CH)`
  - `frame_start <= mode && en && ch_q==0 && dwell_q==0`
- Scan counter update:
  - `mode=0`: `ch_q<=0`, `dwell_q<=0`. Every entry into scan starts at channel 0.
  - `mode=1, en=0`: hold both counters. `y` keeps re-sampling `data[ch_q]` and `valid=0`.
  - `mode=1, en=1, dwell_q<DWELL-1`: `dwell_q++`.
  - `mode=1, en=1, dwell_q==DWELL-1`: `dwell_q<=0`. `ch_q <= (ch_q==N_CH-1) ? 0 : ch_q+1`. Wrap is explicit, so a non-power-of-2 N_CH never reaches an index ≥ N_CH.
- Effective states:
  - MANUAL (mode=0)
  - SCAN_RUN (mode=1, en=1)
  - SCAN_PAUSE (mode=1, en=0)
- Transitions follow `mode` and `en` each cycle, with no handshake delay.
- Manual out-of-range select (N_CH not a power of 2): `y=0`, `valid=0`, and `ch` reports the raw select value.

## Timing
- Reset (`rst_n` low, asynchronous): `y=0`, `ch=0`, `valid=0`, `frame_start=0`, `ch_q=0`, `dwell_q=0`. Release is taken at the next rising edge.
- Latency is 1 cycle: inputs sampled at edge t appear on outputs after edge t.
- Scan, DWELL=D:
  - Each channel is on `y` for exactly D consecutive en=1 cycles.
  - A frame is N_CH*D en=1 cycles.
  - `frame_start` is a 1-cycle pulse per frame.
- Manual→scan switch: the first scan output cycle shows channel 0 with `frame_start=1` (if en=1).
- Scan→manual switch: the next output shows `select`, and the counters clear.
- Pause then resume: continues from the held `ch_q`/`dwell_q`, with no skipped or repeated dwell counts.
- Reset mid-scan: all state clears immediately. After release the scan restarts at channel 0.
- `data` changes mid-dwell: `y` tracks the new value on the next edge, because there is no sample-and-hold.

## Structure
- Shared package `mux_pkg`:
  - `MODE_MANUAL=1'b0`, `MODE_SCAN=1'b1`
  - a `clog2`-with-minimum-1 function, used by this block and future mux variants
- Sub-module `scan_counter` (params N_CH, DWELL):
  - inputs: `clk`, `rst_n`, `clr`, `en`
  - outputs: `ch_q`, `dwell_q`, `wrap`
  - `clr` = manual mode
- The top level contains the select mux, the range check and the output registers.
- Elaboration check: fatal if N_CH<2, W<1 or DWELL<1.

## Test plan
- Manual, N_CH=16, W=1, `data=16'hABAB`, select 0..15, one per cycle → `y` = 1,1,0,1,0,1,0,1,1,1,0,1,0,1,0,1 one cycle behind, `valid=1`, `ch` = select delayed by 1.
- Scan, same data, DWELL=1, en=1 for 40 cycles → `y` repeats that bit sequence, `ch` 0..15 wrapping, `frame_start` high on cycles 1, 17, 33 after mode rises.
- Scan, N_CH=5, W=8, DWELL=3, channels `8'h10..8'h14` → each value held 3 cycles, `ch` sequence 0,0,0,1,1,1…4,4,4,0, wrap after 15 cycles, no index 5–7 ever seen.
- Pause: the same config with en low for 4 cycles in the middle of channel 2 dwell count 1 → `valid=0`, `ch=2` held. On resume channel 2 gets exactly 2 more valid cycles.
- Out-of-range: N_CH=10, manual select=12 → `y=0`, `valid=0`, `ch=12`. Then select=9 → `y=data[9]`, `valid=1`.
- Reset mid-scan at channel 3 (asynchronous, between edges) → all outputs 0 immediately. After release with mode=1, en=1 → `ch=0`, `frame_start=1` on the first output cycle.
